pipe_stage_reg: RTL and testbench

Parametrised pipeline stage register that replaces the per-stage hand-built register banks between IF/ID, ID/EX, EX/MEM and MEM/WB. It moves one instruction slot per cycle and carries:
- the instruction word, a configurable number of data words, and a configurable number of unified register-address (URA) forwarding channels;
- the T_new countdown, which it decrements on each advance;
- a valid bit.

It adds stall (hold) and flush (bubble insertion) with defined priority, so the hazard unit drives one uniform control pair at every stage.

---
 rtl/pipe_stage_reg.sv | 94 +++++++++
 tb/tb_pipe_stage_reg.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register: carries one instruction slot (inst, payload, URA channels, T_new, valid) per cycle.
// Latency: 1 cycle, all outputs registered; async active-low reset clears every output at once.
// Backpressure: enable=0 holds the slot (stall), flush=1 loads a bubble and overrides enable.
// Optional PIPE_STAGE_DEBUG_EN builds the pc_out register and stall_cnt counter; otherwise both read 0.
module pipe_stage_reg #(
    parameter int DATA_W   = 32,
    parameter int N_DATA   = 2,
    parameter int URA_W    = 7,
    parameter int N_URA    = 4,
    parameter int TNEW_W   = 2,
    parameter int TNEW_DEC = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    input  logic                      flush,
    input  logic                      valid_in,
    input  logic [DATA_W-1:0]         inst_in,
    input  logic [N_DATA*DATA_W-1:0]  data_in,
    input  logic [N_URA*URA_W-1:0]    ura_in,
    input  logic [TNEW_W-1:0]         t_new_in,
    input  logic [31:0]               pc_in,
    output logic                      valid_out,
    output logic [DATA_W-1:0]         inst_out,
    output logic [N_DATA*DATA_W-1:0]  data_out,
    output logic [N_URA*URA_W-1:0]    ura_out,
    output logic [TNEW_W-1:0]         t_new_out,
    output logic [31:0]               pc_out,
    output logic [7:0]                stall_cnt
);

    logic [TNEW_W-1:0] t_new_cap;

    // T_new value to store on capture: saturating decrement (never wraps below 0) or straight copy
    always_comb begin
        t_new_cap = t_new_in;
        if ((TNEW_DEC != 0) && (t_new_in != '0)) begin
            t_new_cap = t_new_in - TNEW_W'(1);
        end
    end

    // Slot register: flush loads a bubble, enable captures, otherwise hold.
    // An invalid slot is stored with URA and T_new zeroed so it can never produce a forwarding match.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_out <= 1'b0;
            inst_out  <= '0;
            data_out  <= '0;
            ura_out   <= '0;
            t_new_out <= '0;
        end else if (flush) begin
            valid_out <= 1'b0;
            inst_out  <= '0;
            data_out  <= '0;
            ura_out   <= '0;
            t_new_out <= '0;
        end else if (enable) begin
            valid_out <= valid_in;
            inst_out  <= inst_in;
            data_out  <= data_in;
            ura_out   <= valid_in ? ura_in    : '0;
            t_new_out <= valid_in ? t_new_cap : '0;
        end
    end

`ifdef PIPE_STAGE_DEBUG_EN
    // PC trace register: follows pc_in on capture and on flush so bubbles still show their position
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_out <= '0;
        end else if (flush || enable) begin
            pc_out <= pc_in;
        end
    end

    // Consecutive hold cycles of a valid slot; restarts on every load, saturates at 255
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt <= '0;
        end else if (flush || enable) begin
            stall_cnt <= '0;
        end else if (valid_out && (stall_cnt != 8'hFF)) begin
            stall_cnt <= stall_cnt + 8'd1;
        end
    end
`else
    // Debug trace not built: outputs are constant and pc_in is deliberately left unused
    logic unused_pc_in;
    assign unused_pc_in = ^pc_in;
    assign pc_out       = '0;
    assign stall_cnt    = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
module tb_pipe_stage_reg;

    typedef struct packed {
        logic        valid;
        logic [31:0] inst;
        logic [63:0] data;
        logic [27:0] ura;
        logic [1:0]  tnew;
        logic [31:0] pc;
        logic [7:0]  cnt;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable, flush, valid_in;
    logic [31:0] inst_in;
    logic [63:0] data_in;
    logic [27:0] ura_in;
    logic [1:0]  t_new_in;
    logic [31:0] pc_in;
    logic        valid_out;
    logic [31:0] inst_out;
    logic [63:0] data_out;
    logic [27:0] ura_out;
    logic [1:0]  t_new_out;
    logic [31:0] pc_out;
    logic [7:0]  stall_cnt;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    exp_t zero_e;

    pipe_stage_reg #(
        .DATA_W(32), .N_DATA(2), .URA_W(7), .N_URA(4), .TNEW_W(2), .TNEW_DEC(1)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .flush(flush),
        .valid_in(valid_in), .inst_in(inst_in), .data_in(data_in), .ura_in(ura_in),
        .t_new_in(t_new_in), .pc_in(pc_in),
        .valid_out(valid_out), .inst_out(inst_out), .data_out(data_out), .ura_out(ura_out),
        .t_new_out(t_new_out), .pc_out(pc_out), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    // Expected debug values: only present when the debug trace is built
    function automatic exp_t mk(input logic v, input logic [31:0] inst, input logic [63:0] data,
                                input logic [27:0] ura, input logic [1:0] tn,
                                input logic [31:0] pc, input logic [7:0] cnt);
        exp_t e;
        e.valid = v; e.inst = inst; e.data = data; e.ura = ura; e.tnew = tn;
`ifdef PIPE_STAGE_DEBUG_EN
        e.pc = pc; e.cnt = cnt;
`else
        e.pc = 32'h0; e.cnt = 8'h0;
`endif
        return e;
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", name, got, want, $time);
        end
    endtask

    task automatic check_all(input string tag, input exp_t e);
        chk({tag, ".valid"}, 64'(valid_out), 64'(e.valid));
        chk({tag, ".inst"},  64'(inst_out),  64'(e.inst));
        chk({tag, ".data"},  data_out,       e.data);
        chk({tag, ".ura"},   64'(ura_out),   64'(e.ura));
        chk({tag, ".tnew"},  64'(t_new_out), 64'(e.tnew));
        chk({tag, ".pc"},    64'(pc_out),    64'(e.pc));
        chk({tag, ".cnt"},   64'(stall_cnt), 64'(e.cnt));
    endtask

    // Drive one cycle of inputs (called right after a falling edge) and queue the expected post-edge state
    task automatic cyc(input logic en, input logic fl, input logic v, input logic [31:0] inst,
                       input logic [63:0] data, input logic [27:0] ura, input logic [1:0] tn,
                       input logic [31:0] pc, input exp_t e);
        enable = en; flush = fl; valid_in = v; inst_in = inst; data_in = data;
        ura_in = ura; t_new_in = tn; pc_in = pc;
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    // Monitor: the DUT presents a new slot state after every rising edge; compare against the queue head
    initial begin
        int n = 0;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                exp_t e;
                e = exp_q.pop_front();
                n++;
                check_all($sformatf("scb%0d", n), e);
            end
        end
    end

    // Watchdog
    initial begin
        #50000;
        $display("FAIL watchdog timeout got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [63:0] g64;
        logic [27:0] g28;
        g64 = 64'hFFFF_FFFF_FFFF_FFFF;
        g28 = 28'hFFF_FFFF;
        zero_e = '0;

        // Reset held low with busy inputs: everything must read 0
        reset = 1'b0; enable = 1'b1; flush = 1'b0; valid_in = 1'b1;
        inst_in = 32'hDEADBEEF; data_in = g64; ura_in = g28; t_new_in = 2'd3; pc_in = 32'hCAFE;
        @(posedge clk); @(posedge clk); #1;
        check_all("reset", zero_e);
        @(negedge clk);
        reset = 1'b1;

        // Pass-through: t_new 2 -> 1
        cyc(1, 0, 1, 32'h012A4020, {32'h11111111, 32'h22222222}, {7'd8, 7'd9, 7'd10, 7'd0}, 2'd2, 32'h3000,
            mk(1, 32'h012A4020, {32'h11111111, 32'h22222222}, {7'd8, 7'd9, 7'd10, 7'd0}, 2'd1, 32'h3000, 8'd0));
        // Saturation: t_new 0 stays 0
        cyc(1, 0, 1, 32'h8C000004, {32'h33333333, 32'h44444444}, {7'd1, 7'd2, 7'd3, 7'd4}, 2'd0, 32'h3004,
            mk(1, 32'h8C000004, {32'h33333333, 32'h44444444}, {7'd1, 7'd2, 7'd3, 7'd4}, 2'd0, 32'h3004, 8'd0));
        // t_new 3 -> 2, then stall for three edges with garbage on the inputs
        cyc(1, 0, 1, 32'hAC010008, {32'h55555555, 32'h66666666}, {7'd1, 7'd0, 7'd0, 7'd0}, 2'd3, 32'h3018,
            mk(1, 32'hAC010008, {32'h55555555, 32'h66666666}, {7'd1, 7'd0, 7'd0, 7'd0}, 2'd2, 32'h3018, 8'd0));
        for (int i = 1; i <= 3; i++) begin
            cyc(0, 0, 1, 32'hFFFFFFFF, g64, g28, 2'd3, 32'hDEAD,
                mk(1, 32'hAC010008, {32'h55555555, 32'h66666666}, {7'd1, 7'd0, 7'd0, 7'd0}, 2'd2, 32'h3018, 8'(i)));
        end
        // Resume: new slot, counter restarts
        cyc(1, 0, 1, 32'h00221820, {32'h77777777, 32'h88888888}, {7'd3, 7'd0, 7'd0, 7'd0}, 2'd1, 32'h301C,
            mk(1, 32'h00221820, {32'h77777777, 32'h88888888}, {7'd3, 7'd0, 7'd0, 7'd0}, 2'd0, 32'h301C, 8'd0));
        // Flush wins over enable=0: bubble, pc kept
        cyc(0, 1, 1, 32'h00001234, g64, {7'd9, 7'd9, 7'd9, 7'd9}, 2'd2, 32'h3008,
            mk(0, 32'h0, 64'h0, 28'h0, 2'd0, 32'h3008, 8'd0));
        // Hold on a bubble: counter stays 0
        cyc(0, 0, 1, 32'hFFFFFFFF, g64, g28, 2'd3, 32'hBEEF,
            mk(0, 32'h0, 64'h0, 28'h0, 2'd0, 32'h3008, 8'd0));
        // Flush wins over enable=1
        cyc(1, 1, 1, 32'h012A4020, {32'h11111111, 32'h22222222}, {7'd8, 7'd9, 7'd10, 7'd0}, 2'd2, 32'h3020,
            mk(0, 32'h0, 64'h0, 28'h0, 2'd0, 32'h3020, 8'd0));
        // Invalid capture: URA and t_new forced to 0, rest stored
        cyc(1, 0, 0, 32'h0000BEEF, {32'hAAAAAAAA, 32'hBBBBBBBB}, {7'd5, 7'd6, 7'd7, 7'd1}, 2'd2, 32'h3024,
            mk(0, 32'h0000BEEF, {32'hAAAAAAAA, 32'hBBBBBBBB}, 28'h0, 2'd0, 32'h3024, 8'd0));
        // Valid capture then two stall cycles
        cyc(1, 0, 1, 32'h02324820, {32'hCCCCCCCC, 32'hDDDDDDDD}, {7'd9, 7'd0, 7'd0, 7'd0}, 2'd2, 32'h3028,
            mk(1, 32'h02324820, {32'hCCCCCCCC, 32'hDDDDDDDD}, {7'd9, 7'd0, 7'd0, 7'd0}, 2'd1, 32'h3028, 8'd0));
        for (int i = 1; i <= 2; i++) begin
            cyc(0, 0, 0, 32'h0, 64'h0, 28'h0, 2'd0, 32'h0,
                mk(1, 32'h02324820, {32'hCCCCCCCC, 32'hDDDDDDDD}, {7'd9, 7'd0, 7'd0, 7'd0}, 2'd1, 32'h3028, 8'(i)));
        end

        // Asynchronous reset mid-stall: outputs clear before the next rising edge
        #2;
        reset = 1'b0;
        #1;
        check_all("async_rst", zero_e);
        enable = 1'b1; valid_in = 1'b1; inst_in = 32'h12345678; t_new_in = 2'd3; pc_in = 32'h3030;
        @(posedge clk); #1;
        check_all("rst_edge", zero_e);
        @(negedge clk);
        reset = 1'b1;
        // First edge after release captures; back-to-back slots with no gaps
        cyc(1, 0, 1, 32'h012A4020, {32'h11111111, 32'h22222222}, {7'd8, 7'd9, 7'd10, 7'd0}, 2'd3, 32'h3040,
            mk(1, 32'h012A4020, {32'h11111111, 32'h22222222}, {7'd8, 7'd9, 7'd10, 7'd0}, 2'd2, 32'h3040, 8'd0));
        cyc(1, 0, 1, 32'h8C000004, {32'h33333333, 32'h44444444}, {7'd1, 7'd2, 7'd3, 7'd4}, 2'd1, 32'h3044,
            mk(1, 32'h8C000004, {32'h33333333, 32'h44444444}, {7'd1, 7'd2, 7'd3, 7'd4}, 2'd0, 32'h3044, 8'd0));

        @(negedge clk);
        chk("scb_drained", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
